// File: rtl/fpu_operand_loader.sv
// Nibble-serial operand front-end for the 16-bit FPU core: assembles A/B over 4 beats,
// queues complete pairs in a 2-entry FWFT FIFO and flags overrun / partial-word timeout.
module fpu_operand_loader #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    input  logic [3:0]  i_in_nib_a,
    input  logic [3:0]  i_in_nib_b,
    input  logic        i_in_op,
    input  logic        i_clear,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_a,
    output logic [15:0] o_out_b,
    output logic        o_out_op,
    output logic [1:0]  o_beat_cnt,
    output logic [1:0]  o_fifo_level,
    output logic        o_overrun,
    output logic        o_timeout
);

    localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

    logic        r_run;
    logic [11:0] r_asm_a;
    logic [11:0] r_asm_b;
    logic [1:0]  r_beat_cnt;
    logic [7:0]  r_idle;
    logic [32:0] r_mem [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_level;
    logic        r_overrun;
    logic        r_timeout;

    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_idle_hit;
    logic [32:0] w_word;
    logic [32:0] w_head;

    assign w_pop      = (r_level != 2'd0) && i_out_ready;
    assign w_push_req = i_in_valid && (r_beat_cnt == 2'd3);
    assign w_push     = w_push_req && ((r_level != 2'd2) || w_pop);
    assign w_idle_hit = !i_in_valid && (r_beat_cnt != 2'd0) && ((r_idle + 8'd1) == TimeoutCnt);
    // Beat 3 nibbles bypass the assembly registers straight into the FIFO word.
    assign w_word     = {i_in_nib_a, r_asm_a, i_in_nib_b, r_asm_b, i_in_op};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run      <= 1'b0;
            r_asm_a    <= '0;
            r_asm_b    <= '0;
            r_beat_cnt <= '0;
            r_idle     <= '0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_level    <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else if (!r_run) begin
            // First edge after release only arms the block; beats start on the next one.
            r_run <= 1'b1;
        end else if (i_clear) begin
            r_beat_cnt <= '0;
            r_idle     <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_level    <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (i_in_valid) begin
                r_idle     <= '0;
                r_beat_cnt <= r_beat_cnt + 2'd1;
                case (r_beat_cnt)
                    2'd0: begin
                        r_asm_a[3:0] <= i_in_nib_a;
                        r_asm_b[3:0] <= i_in_nib_b;
                    end
                    2'd1: begin
                        r_asm_a[7:4] <= i_in_nib_a;
                        r_asm_b[7:4] <= i_in_nib_b;
                    end
                    2'd2: begin
                        r_asm_a[11:8] <= i_in_nib_a;
                        r_asm_b[11:8] <= i_in_nib_b;
                    end
                    default: ;
                endcase
            end else if (w_idle_hit) begin
                r_beat_cnt <= '0;
                r_idle     <= '0;
                r_timeout  <= 1'b1;
            end else if (r_beat_cnt != 2'd0) begin
                r_idle <= r_idle + 8'd1;
            end

            if (w_push_req && !w_push) begin
                r_overrun <= 1'b1;
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_level <= r_level + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_comb begin
        o_out_valid  = (r_level != 2'd0);
        o_out_a      = o_out_valid ? w_head[32:17] : 16'h0000;
        o_out_b      = o_out_valid ? w_head[16:1]  : 16'h0000;
        o_out_op     = o_out_valid ? w_head[0]     : 1'b0;
        o_beat_cnt   = r_beat_cnt;
        o_fifo_level = r_level;
        o_overrun    = r_overrun;
        o_timeout    = r_timeout;
    end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Self-checking bench for fpu_operand_loader: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_fpu_operand_loader;

    localparam int unsigned TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic        in_op;
    logic        clear;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic        out_op;
    logic [1:0]  beat_cnt;
    logic [1:0]  fifo_level;
    logic        overrun;
    logic        timeout;

    fpu_operand_loader #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_in_valid   (in_valid),
        .i_in_nib_a   (nib_a),
        .i_in_nib_b   (nib_b),
        .i_in_op      (in_op),
        .i_clear      (clear),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_a      (out_a),
        .o_out_b      (out_b),
        .o_out_op     (out_op),
        .o_beat_cnt   (beat_cnt),
        .o_fifo_level (fifo_level),
        .o_overrun    (overrun),
        .o_timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus a nibble list, driven by the rules directly.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
    } word_t;

    word_t      mq[$];
    logic [3:0] m_na[4];
    logic [3:0] m_nb[4];
    int         m_beats;
    int         m_idle;
    bit         m_ovr;
    bit         m_to;
    bit         m_run;

    task automatic model_reset();
        mq.delete();
        m_beats = 0;
        m_idle  = 0;
        m_ovr   = 0;
        m_to    = 0;
        m_run   = 0;
    endtask

    task automatic model_edge();
        word_t w;
        if (!rst_n) return;
        if (!m_run) begin
            m_run = 1;
            return;
        end
        if (clear) begin
            mq.delete();
            m_beats = 0;
            m_idle  = 0;
            m_ovr   = 0;
            m_to    = 0;
            return;
        end
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (in_valid) begin
            m_na[m_beats] = nib_a;
            m_nb[m_beats] = nib_b;
            m_idle = 0;
            if (m_beats == 3) begin
                w.a  = {m_na[3], m_na[2], m_na[1], m_na[0]};
                w.b  = {m_nb[3], m_nb[2], m_nb[1], m_nb[0]};
                w.op = in_op;
                if (mq.size() < 2) mq.push_back(w);
                else m_ovr = 1;
                m_beats = 0;
            end else begin
                m_beats++;
            end
        end else if (m_beats != 0) begin
            m_idle++;
            if (m_idle == int'(TIMEOUT)) begin
                m_beats = 0;
                m_idle  = 0;
                m_to    = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_beats(input logic [15:0] a, input logic [15:0] b, input logic op,
                              input int first, input int last);
        for (int k = first; k <= last; k++) begin
            in_valid = 1'b1;
            nib_a    = a[4*k +: 4];
            nib_b    = b[4*k +: 4];
            in_op    = (k == 3) ? op : ~op;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic op);
        send_beats(a, b, op, 0, 3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_model();
        chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        chk("m_level", {30'd0, fifo_level}, mq.size());
        chk("m_beat", {30'd0, beat_cnt}, m_beats);
        chk("m_ovr", {31'd0, overrun}, {31'd0, m_ovr});
        chk("m_to", {31'd0, timeout}, {31'd0, m_to});
        if (mq.size() != 0) begin
            chk("m_a", {16'd0, out_a}, {16'd0, mq[0].a});
            chk("m_b", {16'd0, out_b}, {16'd0, mq[0].b});
            chk("m_op", {31'd0, out_op}, {31'd0, mq[0].op});
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        eop;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{a: 16'h3C00, b: 16'h4000, op: 1'b1, ea: 16'h3C00, eb: 16'h4000, eop: 1'b1};
        vecs[1] = '{a: 16'hC000, b: 16'h3800, op: 1'b0, ea: 16'hC000, eb: 16'h3800, eop: 1'b0};
        vecs[2] = '{a: 16'h7BFF, b: 16'h0001, op: 1'b1, ea: 16'h7BFF, eb: 16'h0001, eop: 1'b1};
        vecs[3] = '{a: 16'hFFFF, b: 16'h0000, op: 1'b0, ea: 16'hFFFF, eb: 16'h0000, eop: 1'b0};
        vecs[4] = '{a: 16'h0001, b: 16'h8000, op: 1'b1, ea: 16'h0001, eb: 16'h8000, eop: 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; nib_a = '0; nib_b = '0; in_op = 1'b0;
        clear = 1'b0; out_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        idle(2);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_level", {30'd0, fifo_level}, 0);
        chk("rst_beat", {30'd0, beat_cnt}, 0);
        chk("rst_flags", {30'd0, overrun, timeout}, 0);
        rst_n = 1'b1;
        tick();

        // Table of single words with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_word(vecs[i].a, vecs[i].b, vecs[i].op);
            chk("vec_valid", {31'd0, out_valid}, 1);
            chk("vec_a", {16'd0, out_a}, {16'd0, vecs[i].ea});
            chk("vec_b", {16'd0, out_b}, {16'd0, vecs[i].eb});
            chk("vec_op", {31'd0, out_op}, {31'd0, vecs[i].eop});
            tick();
            chk("vec_drain", {31'd0, out_valid}, 0);
        end

        // Backpressure and overrun.
        out_ready = 1'b0;
        send_word(16'h1111, 16'h2222, 1'b1);
        send_word(16'h3333, 16'h4444, 1'b0);
        send_word(16'h5555, 16'h6666, 1'b1);
        chk("bp_level", {30'd0, fifo_level}, 2);
        chk("bp_ovr", {31'd0, overrun}, 1);
        chk("bp_head_a", {16'd0, out_a}, 32'h1111);
        chk("bp_head_b", {16'd0, out_b}, 32'h2222);
        out_ready = 1'b1;
        tick();
        chk("bp_pop2_a", {16'd0, out_a}, 32'h3333);
        chk("bp_pop2_b", {16'd0, out_b}, 32'h4444);
        chk("bp_pop2_lvl", {30'd0, fifo_level}, 1);
        tick();
        chk("bp_empty", {30'd0, fifo_level}, 0);

        // Clear on beat 3 while overrun is set; FIFO holds two words.
        out_ready = 1'b0;
        send_word(16'h0A0A, 16'h0B0B, 1'b0);
        send_word(16'h0C0C, 16'h0D0D, 1'b1);
        send_beats(16'hEEEE, 16'hDDDD, 1'b1, 0, 2);
        clear = 1'b1;
        send_beats(16'hEEEE, 16'hDDDD, 1'b1, 3, 3);
        clear = 1'b0;
        chk("clr_level", {30'd0, fifo_level}, 0);
        chk("clr_beat", {30'd0, beat_cnt}, 0);
        chk("clr_ovr", {31'd0, overrun}, 0);
        tick();
        chk("clr_valid", {31'd0, out_valid}, 0);

        // Full FIFO with a pop on the same edge as beat 3.
        send_word(16'h0102, 16'h0304, 1'b0);
        send_word(16'h0506, 16'h0708, 1'b1);
        send_beats(16'hAAAA, 16'h5555, 1'b1, 0, 2);
        out_ready = 1'b1;
        send_beats(16'hAAAA, 16'h5555, 1'b1, 3, 3);
        out_ready = 1'b0;
        chk("sp_ovr", {31'd0, overrun}, 0);
        chk("sp_level", {30'd0, fifo_level}, 2);
        chk("sp_head", {16'd0, out_a}, 32'h0506);
        out_ready = 1'b1;
        tick();
        chk("sp_third_a", {16'd0, out_a}, 32'hAAAA);
        chk("sp_third_b", {16'd0, out_b}, 32'h5555);
        tick();
        chk("sp_empty", {31'd0, out_valid}, 0);

        // 14 idle cycles mid-word must not time out.
        send_beats(16'h1234, 16'h5678, 1'b0, 0, 1);
        idle(TIMEOUT - 1);
        chk("to14_flag", {31'd0, timeout}, 0);
        chk("to14_beat", {30'd0, beat_cnt}, 2);
        send_beats(16'h1234, 16'h5678, 1'b0, 2, 3);
        chk("to14_a", {16'd0, out_a}, 32'h1234);
        chk("to14_b", {16'd0, out_b}, 32'h5678);
        tick();

        // 15 idle cycles discards the partial word.
        send_beats(16'h9999, 16'h9999, 1'b1, 0, 1);
        idle(TIMEOUT - 1);
        chk("to_before", {31'd0, timeout}, 0);
        tick();
        chk("to_flag", {31'd0, timeout}, 1);
        chk("to_beat", {30'd0, beat_cnt}, 0);
        send_word(16'hC000, 16'h3800, 1'b0);
        chk("to_next_a", {16'd0, out_a}, 32'hC000);
        chk("to_next_b", {16'd0, out_b}, 32'h3800);
        tick();

        // Reset with a queued word, a partial word and a sticky flag.
        out_ready = 1'b0;
        send_word(16'h1357, 16'h2468, 1'b1);
        send_beats(16'hFFFF, 16'hFFFF, 1'b1, 0, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_valid", {31'd0, out_valid}, 0);
        chk("mr_a", {16'd0, out_a}, 0);
        chk("mr_b", {16'd0, out_b}, 0);
        chk("mr_op", {31'd0, out_op}, 0);
        chk("mr_beat", {30'd0, beat_cnt}, 0);
        chk("mr_level", {30'd0, fifo_level}, 0);
        chk("mr_flags", {30'd0, overrun, timeout}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send_word(16'h7BFF, 16'h0001, 1'b1);
        chk("mr_new_a", {16'd0, out_a}, 32'h7BFF);
        chk("mr_new_b", {16'd0, out_b}, 32'h0001);
        chk("mr_new_op", {31'd0, out_op}, 1);
        tick();

        // Randomized traffic against the model, with varying beat density.
        for (int seg = 0; seg < 6; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 50 : 6);
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(99) < pct);
                nib_a     = 4'($urandom);
                nib_b     = 4'($urandom);
                in_op     = 1'($urandom);
                out_ready = ($urandom_range(99) < 50);
                clear     = ($urandom_range(199) == 0);
                tick();
                chk_model();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_operand_loader.md
# fpu_operand_loader

Upstream front-end for the 16-bit FPU core (adder/multiplier). It assembles two half-precision operands from 4-bit nibble beats on the chip pins and captures the add/mul select. Completed operand pairs are queued in a 2-entry FIFO, then presented to the FPU core over a valid/ready handshake. It also detects dropped words (overrun) and stalled partial words (timeout).

## Interface
- TIMEOUT, 15: idle cycles tolerated between beats of a partial word before it is discarded (1..255).
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat strobe; nibbles sampled on every rising edge where high.
- in_nib_a  in  4  operand A nibble.
- in_nib_b  in  4  operand B nibble.
- in_op  in  1  operation select, 1 = add, 0 = mul; sampled only on the 4th beat.
- clear  in  1  synchronous clear of beat state, FIFO and sticky flags.
- out_valid  out  1  FIFO head holds a complete operand pair.
- out_ready  in  1  FPU core accepts the head this cycle.
- out_a  out  16  operand A at FIFO head.
- out_b  out  16  operand B at FIFO head.
- out_op  out  1  op select at FIFO head.
- beat_cnt  out  2  beats collected for the current word (0..3).
- fifo_level  out  2  entries queued (0..2).
- overrun  out  1  sticky; a completed word was dropped because the FIFO was full.
- timeout  out  1  sticky; a partial word was discarded by the idle timer.

## Operation
- Beat k (k = beat_cnt, 0..3) writes in_nib_a and in_nib_b into bits [4k+3:4k] of the A and B assembly registers. Order is LSB nibble first.
- On beat 3, the word {A, B, in_op} is pushed into the FIFO and beat_cnt returns to 0.
- Push is accepted when fifo_level < 2, or when fifo_level == 2 and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overrun is set, and FIFO contents are unchanged.
- The FIFO is first-word-fall-through. out_a, out_b and out_op come from the head entry.
  - out_valid = (fifo_level != 0).
  - Pop occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* are held stable.
- Simultaneous push and pop: fifo_level is unchanged and order is preserved, so the popped head is older than the pushed word.
- Idle timer:
  - Cleared on any in_valid.
  - Increments each cycle while beat_cnt != 0 && !in_valid.
  - On reaching TIMEOUT: beat_cnt goes to 0, the partial word is discarded, timeout is set, and the timer clears.
  - The timer does not run while beat_cnt == 0.
- clear has priority over in_valid, push and pop in the same cycle. It sets beat_cnt = 0, empties the FIFO, clears the idle timer and clears overrun and timeout.
  - Assembly registers need not be cleared; they are fully overwritten before reuse.
- The operand contents are opaque; no FP interpretation happens in this block.

## Timing
- Reset asserted low: all outputs go to 0 immediately (out_valid, out_a, out_b, out_op, beat_cnt, fifo_level, overrun, timeout). The idle timer and FIFO pointers are also 0.
- Reset mid-word or with data queued: the partial word and all queued words are lost.
- Reset release is internally synchronised to clock. First beat is accepted on the 2nd rising edge after deassertion.
- Latency: the edge sampling beat 3 into an empty FIFO makes out_valid = 1 on the cycle after it, with out_a/out_b/out_op valid in that same cycle.
- Throughput: one word per 4 beats, with no bubble. Back-to-back in_valid is supported indefinitely with out_ready = 1.
- Flags set on the edge of the triggering event, visible the following cycle. They remain set until clear or reset.
- beat_cnt and fifo_level are registered and reflect state after the most recent edge.

## Test plan
- Basic add:
  - Stimulus: A = 0x3C00, B = 0x4000, A nibbles 0,0,C,3 and B nibbles 0,0,0,4 on 4 consecutive beats, in_op = 1 on beat 3, out_ready = 1.
  - Required: one cycle after beat 3, out_valid = 1, out_a = 0x3C00, out_b = 0x4000, out_op = 1. out_valid = 0 the next cycle.
- Backpressure and overrun:
  - Stimulus: out_ready = 0; send words 0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666.
  - Required: fifo_level = 2 and overrun = 1 after the third word. Then out_ready = 1 pops 0x1111/0x2222 then 0x3333/0x4444, and fifo_level returns to 0.
- Full plus simultaneous pop:
  - Stimulus: FIFO holds 2 words and out_ready is pulsed on the same edge as beat 3 of a third word 0xAAAA/0x5555.
  - Required: the third word is accepted, overrun stays 0, fifo_level stays 2, and the head advances to the second word.
- Timeout:
  - Stimulus: TIMEOUT = 15; 2 beats, then 15 idle cycles.
  - Required: timeout = 1 and beat_cnt = 0. A following clean 4-beat word 0xC000/0x3800 emerges intact. At 14 idle cycles, no timeout.
- Reset mid-word:
  - Stimulus: 1 queued word plus 2 beats, then reset low for 1 cycle.
  - Required: all outputs 0 immediately. After release, a new word 0x7BFF/0x0001 emerges correctly, with no stale nibbles.
- Clear priority:
  - Stimulus: clear asserted together with beat 3 while overrun = 1.
  - Required: the word is not pushed, fifo_level = 0, beat_cnt = 0 and overrun = 0.
